// File: rtl/video_axis_sink.sv
// video_axis_sink
// AXI4-Stream video sink that checks each frame against an expected geometry.
// It measures line length and frame height, pulses SOF/EOL error flags,
// keeps saturating frame/error counters and reports lock after a clean frame.
// tdata is ignored.
//
// Build option: define VIDEO_SINK_BP_EN to throttle s_axis_tready with a
// 16-bit Fibonacci LFSR (taps 16,14,13,11). Without it, tready = en & ~rst.
//
// state     | meaning
// ----------+-------------------------------------------
// ST_SYNC   | waiting for an SOF (tuser) beat
// ST_ACTIVE | inside a frame, counting pixels and lines
module video_axis_sink #(
    parameter int DATAW = 24,
    parameter int CNTW  = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [12:0]      exp_width,
    input  logic [12:0]      exp_height,
    input  logic [DATAW-1:0] s_axis_tdata,
    input  logic             s_axis_tvalid,
    input  logic             s_axis_tuser,
    input  logic             s_axis_tlast,
    output logic             s_axis_tready,
    output logic [12:0]      meas_width,
    output logic [12:0]      meas_height,
    output logic             frame_done,
    output logic             err_sof,
    output logic             err_eol_early,
    output logic             err_eol_late,
    output logic [CNTW-1:0]  frame_cnt,
    output logic [CNTW-1:0]  err_cnt,
    output logic             locked
);

    typedef enum logic {
        ST_SYNC   = 1'b0,
        ST_ACTIVE = 1'b1
    } state_t;

    localparam logic [12:0] PIX_MAX = 13'h1FFF;

    state_t          r_state;
    state_t          w_state_nxt;

    logic [12:0]     r_pix;
    logic [12:0]     r_line;
    logic            r_late_seen;
    logic            r_frame_err;
    logic [12:0]     r_meas_width;
    logic [12:0]     r_meas_height;
    logic            r_frame_done;
    logic            r_err_sof;
    logic            r_err_early;
    logic            r_err_late;
    logic            r_lock_ok;
    logic [CNTW-1:0] r_frame_cnt;
    logic [CNTW-1:0] r_err_cnt;
    logic            r_locked;

    logic            w_ready;
    logic            w_acc;
    logic            w_in_frame;
    logic [12:0]     w_pix_base;
    logic [12:0]     w_line_base;
    logic [12:0]     w_len;
    logic [13:0]     w_line_inc;
    logic            w_frame_end;
    logic            w_late_base;
    logic            w_ferr_base;
    logic            w_sof_nxt;
    logic            w_early_nxt;
    logic            w_late_nxt;
    logic            w_done_nxt;
    logic            w_lock_ok_nxt;
    logic            w_any_err;
    logic            w_unused_tdata;

    assign w_unused_tdata = ^s_axis_tdata;

`ifdef VIDEO_SINK_BP_EN
    logic [15:0] r_lfsr;
    logic        w_lfsr_fb;

    assign w_lfsr_fb = r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10];

    // Pseudo-random ready pattern; frozen while the sink is disabled
    always_ff @(posedge clk) begin
        if (rst) begin
            r_lfsr <= 16'hACE1;
        end else if (en) begin
            r_lfsr <= {r_lfsr[14:0], w_lfsr_fb};
        end
    end

    assign w_ready = en & r_lfsr[0] & ~rst;
`else
    assign w_ready = en & ~rst;
`endif

    assign s_axis_tready = w_ready;
    assign w_acc         = s_axis_tvalid & w_ready;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_SYNC;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state: SOF always (re)enters ACTIVE; the final EOL of a frame returns to SYNC
    always_comb begin
        w_state_nxt = r_state;
        if (w_in_frame) begin
            w_state_nxt = ST_ACTIVE;
            if (w_frame_end) begin
                w_state_nxt = ST_SYNC;
            end
        end
    end

    // Beat decode: an SOF beat restarts counting from zero before being counted itself
    always_comb begin
        w_in_frame    = 1'b0;
        w_pix_base    = r_pix;
        w_line_base   = r_line;
        w_late_base   = r_late_seen;
        w_ferr_base   = r_frame_err;
        w_len         = 13'd0;
        w_line_inc    = 14'd0;
        w_frame_end   = 1'b0;
        w_sof_nxt     = 1'b0;
        w_early_nxt   = 1'b0;
        w_late_nxt    = 1'b0;
        w_done_nxt    = 1'b0;
        w_lock_ok_nxt = 1'b0;

        if (s_axis_tuser) begin
            w_pix_base  = 13'd0;
            w_line_base = 13'd0;
            w_late_base = 1'b0;
            w_ferr_base = 1'b0;
        end

        w_len       = (w_pix_base == PIX_MAX) ? PIX_MAX : w_pix_base + 13'd1;
        w_line_inc  = {1'b0, w_line_base} + 14'd1;
        w_frame_end = s_axis_tlast && (w_line_inc == {1'b0, exp_height});

        if (w_acc) begin
            if (r_state == ST_SYNC) begin
                w_in_frame = s_axis_tuser;
                w_sof_nxt  = !s_axis_tuser && (r_frame_cnt != '0);
            end else begin
                w_in_frame = 1'b1;
                w_sof_nxt  = s_axis_tuser;
            end
        end

        if (w_in_frame) begin
            if (s_axis_tlast) begin
                w_early_nxt = (w_len < exp_width);
                w_done_nxt  = w_frame_end;
            end else begin
                w_late_nxt  = (w_len == exp_width) && !w_late_base;
            end
            w_lock_ok_nxt = w_done_nxt && !w_ferr_base && !w_early_nxt;
        end
    end

    // Frame datapath: pixel/line counters, measurements, registered pulses
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pix         <= '0;
            r_line        <= '0;
            r_late_seen   <= 1'b0;
            r_frame_err   <= 1'b0;
            r_meas_width  <= '0;
            r_meas_height <= '0;
            r_frame_cnt   <= '0;
            r_frame_done  <= 1'b0;
            r_err_sof     <= 1'b0;
            r_err_early   <= 1'b0;
            r_err_late    <= 1'b0;
            r_lock_ok     <= 1'b0;
        end else begin
            r_frame_done <= w_done_nxt;
            r_err_sof    <= w_sof_nxt;
            r_err_early  <= w_early_nxt;
            r_err_late   <= w_late_nxt;
            r_lock_ok    <= w_lock_ok_nxt;
            if (w_in_frame) begin
                if (s_axis_tlast) begin
                    r_pix        <= '0;
                    r_late_seen  <= 1'b0;
                    r_meas_width <= w_len;
                    r_frame_err  <= w_ferr_base | w_early_nxt;
                    if (w_frame_end) begin
                        r_line        <= '0;
                        r_meas_height <= w_line_inc[12:0];
                        if (r_frame_cnt != '1) begin
                            r_frame_cnt <= r_frame_cnt + 1'b1;
                        end
                    end else begin
                        r_line <= w_line_inc[12:0];
                    end
                end else begin
                    r_pix       <= w_len;
                    r_line      <= w_line_base;
                    r_late_seen <= w_late_base | w_late_nxt;
                    r_frame_err <= w_ferr_base | w_late_nxt;
                end
            end
        end
    end

    assign w_any_err = r_err_sof | r_err_early | r_err_late;

    // Error counter and lock follow the registered pulses; an error beats a clean frame_done
    always_ff @(posedge clk) begin
        if (rst) begin
            r_err_cnt <= '0;
            r_locked  <= 1'b0;
        end else begin
            if (w_any_err && (r_err_cnt != '1)) begin
                r_err_cnt <= r_err_cnt + 1'b1;
            end
            if (w_any_err) begin
                r_locked <= 1'b0;
            end else if (r_frame_done && r_lock_ok) begin
                r_locked <= 1'b1;
            end
        end
    end

    // Output drive
    always_comb begin
        meas_width    = r_meas_width;
        meas_height   = r_meas_height;
        frame_done    = r_frame_done;
        err_sof       = r_err_sof;
        err_eol_early = r_err_early;
        err_eol_late  = r_err_late;
        frame_cnt     = r_frame_cnt;
        err_cnt       = r_err_cnt;
        locked        = r_locked;
    end

endmodule

// File: tb/tb_video_axis_sink.sv
// tb_video_axis_sink
// Directed and random stimulus for video_axis_sink, checked every cycle
// against a beat-level model of the frame rules.
module tb_video_axis_sink;

    localparam int DATAW = 24;
    localparam int CNTW  = 16;
    localparam int CMAX  = (1 << CNTW) - 1;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             en  = 1'b1;
    logic [12:0]      exp_width  = 13'd8;
    logic [12:0]      exp_height = 13'd4;
    logic [DATAW-1:0] s_axis_tdata = '0;
    logic             s_axis_tvalid = 1'b0;
    logic             s_axis_tuser  = 1'b0;
    logic             s_axis_tlast  = 1'b0;
    logic             s_axis_tready;
    logic [12:0]      meas_width, meas_height;
    logic             frame_done, err_sof, err_eol_early, err_eol_late;
    logic [CNTW-1:0]  frame_cnt, err_cnt;
    logic             locked;

    video_axis_sink #(.DATAW(DATAW), .CNTW(CNTW)) dut (
        .clk(clk), .rst(rst), .en(en),
        .exp_width(exp_width), .exp_height(exp_height),
        .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid),
        .s_axis_tuser(s_axis_tuser), .s_axis_tlast(s_axis_tlast),
        .s_axis_tready(s_axis_tready),
        .meas_width(meas_width), .meas_height(meas_height),
        .frame_done(frame_done), .err_sof(err_sof),
        .err_eol_early(err_eol_early), .err_eol_late(err_eol_late),
        .frame_cnt(frame_cnt), .err_cnt(err_cnt), .locked(locked)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // model state
    bit m_active, m_ferr, m_late_seen, m_locked;
    int m_pix, m_line, m_fc, m_ec, m_mw, m_mh;
    bit p_fd, p_sof, p_early, p_late, p_lockset;
    bit prev_any, prev_lockset;

    // observation
    int  n_done, n_sof, n_early, n_late, rdy_low_seen, gc;
    bit  g_gap, last_acc;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_errors++;
            $error("FAIL %s got=%0d exp=%0d", tag, obs, expv);
        end
    endtask

    task automatic model_reset();
        m_active = 0; m_ferr = 0; m_late_seen = 0; m_locked = 0;
        m_pix = 0; m_line = 0; m_fc = 0; m_ec = 0; m_mw = 0; m_mh = 0;
        prev_any = 0; prev_lockset = 0;
    endtask

    // One accepted beat, applied with the frame rules in plain arithmetic
    task automatic model_beat(input bit u, input bit l);
        int len;
        if (!m_active && !u) begin
            if (m_fc != 0) p_sof = 1;
            return;
        end
        if (u) begin
            if (m_active) p_sof = 1;
            m_active = 1; m_pix = 0; m_line = 0; m_ferr = 0; m_late_seen = 0;
        end
        len = (m_pix >= 8191) ? 8191 : m_pix + 1;
        if (l) begin
            m_mw = len;
            if (len < int'(exp_width)) begin p_early = 1; m_ferr = 1; end
            m_pix = 0; m_late_seen = 0; m_line++;
            if (m_line == int'(exp_height)) begin
                m_mh = m_line; p_fd = 1; m_active = 0;
                if (m_fc < CMAX) m_fc++;
                p_lockset = !m_ferr;
            end
        end else begin
            m_pix = len;
            if (len == int'(exp_width) && !m_late_seen) begin
                p_late = 1; m_late_seen = 1; m_ferr = 1;
            end
        end
    endtask

    task automatic compare_all();
        chk("frame_done", frame_done, p_fd);
        chk("err_sof", err_sof, p_sof);
        chk("err_eol_early", err_eol_early, p_early);
        chk("err_eol_late", err_eol_late, p_late);
        chk("meas_width", meas_width, m_mw);
        chk("meas_height", meas_height, m_mh);
        chk("frame_cnt", frame_cnt, m_fc);
        chk("err_cnt", err_cnt, m_ec);
        chk("locked", locked, m_locked);
    endtask

    // One clock: drive at negedge, sample #1 after posedge, advance model
    task automatic cycle(input bit v, input bit u, input bit l);
        bit acc;
        @(negedge clk);
        s_axis_tvalid = v; s_axis_tuser = u; s_axis_tlast = l;
        s_axis_tdata = DATAW'($urandom);
        #1;
        acc = v && (s_axis_tready === 1'b1);
        if (s_axis_tready !== 1'b1) rdy_low_seen++;
`ifndef VIDEO_SINK_BP_EN
        chk("tready", s_axis_tready, en && !rst);
`else
        if (!en) chk("tready_en_low", s_axis_tready, 0);
`endif
        @(posedge clk); #1;
        if (prev_any) m_locked = 0;
        else if (prev_lockset) m_locked = 1;
        if (prev_any && m_ec < CMAX) m_ec++;
        p_fd = 0; p_sof = 0; p_early = 0; p_late = 0; p_lockset = 0;
        if (acc) model_beat(u, l);
        prev_any = p_sof | p_early | p_late;
        prev_lockset = p_fd & p_lockset;
        compare_all();
        n_done += frame_done; n_sof += err_sof;
        n_early += err_eol_early; n_late += err_eol_late;
        last_acc = acc;
        gc++;
    endtask

    task automatic send_beat(input bit u, input bit l);
        int tries = 0;
        if (g_gap) while (((gc / 3) % 2) == 1) cycle(0, 0, 0);
        last_acc = 0;
        while (!last_acc && tries < 64) begin
            cycle(1, u, l);
            tries++;
        end
        if (!last_acc) chk("beat_timeout", 0, 1);
    endtask

    task automatic send_line(input int len, input bit sof);
        for (int i = 0; i < len; i++) send_beat(sof && i == 0, i == len - 1);
    endtask

    task automatic send_frame(input int w, input int h);
        for (int ln = 0; ln < h; ln++) send_line(w, ln == 0);
    endtask

    task automatic clr_counts();
        n_done = 0; n_sof = 0; n_early = 0; n_late = 0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1; s_axis_tvalid = 1; s_axis_tuser = 1;
        #1;
        chk("rst_tready", s_axis_tready, 0);
        @(posedge clk); #1;
        chk("rst_meas_w", meas_width, 0);
        chk("rst_meas_h", meas_height, 0);
        chk("rst_pulses", {frame_done, err_sof, err_eol_early, err_eol_late}, 0);
        chk("rst_frame_cnt", frame_cnt, 0);
        chk("rst_err_cnt", err_cnt, 0);
        chk("rst_locked", locked, 0);
        @(negedge clk);
        rst = 0; s_axis_tvalid = 0; s_axis_tuser = 0;
        model_reset();
        clr_counts();
    endtask

    int sv_fc, sv_ec, sv_done;

    initial begin
        model_reset(); clr_counts();
        gc = 0; g_gap = 0; rdy_low_seen = 0;
        do_reset();

        // clean frames
        exp_width = 8; exp_height = 4;
        send_frame(8, 4); send_frame(8, 4);
        cycle(0, 0, 0);
        chk("clean_done", n_done, 2);
        chk("clean_fc", frame_cnt, 2);
        chk("clean_mw", meas_width, 8);
        chk("clean_mh", meas_height, 4);
        chk("clean_lock", locked, 1);
        chk("clean_ec", err_cnt, 0);
        sv_fc = frame_cnt; sv_ec = err_cnt; sv_done = n_done;

        // stray beat in SYNC after a frame
        send_beat(0, 0);
        cycle(0, 0, 0);
        chk("stray_sof", n_sof, 1);
        chk("stray_unlock", locked, 0);

        // short line
        do_reset();
        send_line(8, 1); send_line(6, 0);
        chk("short_mw", meas_width, 6);
        send_line(8, 0); send_line(8, 0);
        cycle(0, 0, 0); cycle(0, 0, 0);
        chk("short_early", n_early, 1);
        chk("short_lock", locked, 0);
        chk("short_done", n_done, 1);

        // long line
        do_reset();
        for (int i = 0; i < 8; i++) send_beat(i == 0, 0);
        chk("late_at_px8", err_eol_late, 1);
        send_beat(0, 0); send_beat(0, 1);
        chk("long_mw", meas_width, 10);
        send_line(8, 0); send_line(8, 0); send_line(8, 0);
        cycle(0, 0, 0);
        chk("long_late", n_late, 1);

        // short frame then full frame
        do_reset();
        send_line(8, 1); send_line(8, 0); send_line(8, 0);
        send_frame(8, 4);
        cycle(0, 0, 0);
        chk("sframe_sof", n_sof, 1);
        chk("sframe_done", n_done, 1);
        chk("sframe_fc", frame_cnt, 1);
        chk("sframe_mh", meas_height, 4);

        // tvalid gaps
        do_reset();
        g_gap = 1;
        send_frame(8, 4); send_frame(8, 4);
        g_gap = 0;
        cycle(0, 0, 0);
        chk("gap_fc", frame_cnt, sv_fc);
        chk("gap_ec", err_cnt, sv_ec);
        chk("gap_done", n_done, sv_done);
        chk("gap_lock", locked, 1);

        // reset mid-line, then a clean frame
        send_line(8, 1); send_beat(0, 0); send_beat(0, 0);
        do_reset();
        send_beat(0, 0); send_beat(0, 1);
        send_frame(8, 4);
        cycle(0, 0, 0);
        chk("rst_mid_fc", frame_cnt, 1);
        chk("rst_mid_ec", err_cnt, 0);

        // en low mid-frame holds state
        send_line(8, 1); send_beat(0, 0); send_beat(0, 0);
        en = 0;
        repeat (5) cycle(1, 1, 1);
        en = 1;
        for (int i = 0; i < 6; i++) send_beat(0, i == 5);
        send_line(8, 0); send_line(8, 0);
        cycle(0, 0, 0);
        chk("en_fc", frame_cnt, 2);
        chk("en_ec", err_cnt, 0);

        // SOF with tlast
        do_reset();
        exp_width = 1; exp_height = 1;
        send_beat(1, 1);
        exp_width = 3; exp_height = 2;
        send_beat(1, 1);
        send_line(3, 0);
        cycle(0, 0, 0);
        chk("sofeol_done", n_done, 2);
        chk("sofeol_early", n_early, 1);

        // random stimulus
        for (int rnd = 0; rnd < 4; rnd++) begin
            do_reset();
            exp_width  = 13'($urandom_range(1, 5));
            exp_height = 13'($urandom_range(1, 3));
            repeat (400) begin
                if ($urandom_range(0, 99) < 20) cycle(0, 0, 0);
                else cycle(1, $urandom_range(0, 99) < 8, $urandom_range(0, 99) < 30);
            end
        end

`ifdef VIDEO_SINK_BP_EN
        do_reset();
        rdy_low_seen = 0;
        exp_width = 16; exp_height = 2;
        repeat (3) send_frame(16, 2);
        cycle(0, 0, 0);
        chk("bp_fc", frame_cnt, 3);
        chk("bp_ec", err_cnt, 0);
        chk("bp_rdy_low", rdy_low_seen > 0, 1);
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
